i2c_req_arbiter: RTL and testbench

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_req_arbiter_if.sv | 34 +++
 rtl/i2c_req_arbiter.sv | 113 +++++++++++
 tb/tb_i2c_req_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the downstream I2C master.
// The arbiter takes the master modport; the bench or the surrounding logic takes the slave modport.
interface i2c_req_arbiter_if;
    logic       Req0;
    logic       Req1;
    logic       Op0;
    logic       Op1;
    logic [7:0] Addr0;
    logic [7:0] Addr1;
    logic [7:0] Data0;
    logic [7:0] Data1;
    logic       Ack0;
    logic       Ack1;
    logic       Err0;
    logic       Err1;
    logic [7:0] RdData0;
    logic [7:0] RdData1;
    logic [1:0] Start_Sig;
    logic [7:0] Addr_Sig;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       Done_Sig;
    logic       Busy;

    modport master (
        input  Req0, Req1, Op0, Op1, Addr0, Addr1, Data0, Data1, RdData, Done_Sig,
        output Ack0, Ack1, Err0, Err1, RdData0, RdData1, Start_Sig, Addr_Sig, WrData, Busy
    );

    modport slave (
        output Req0, Req1, Op0, Op1, Addr0, Addr1, Data0, Data1, RdData, Done_Sig,
        input  Ack0, Ack1, Err0, Err1, RdData0, RdData1, Start_Sig, Addr_Sig, WrData, Busy
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Two-requester arbiter in front of a single I2C register master: round-robin tie-break,
// one transaction in flight, BUSY timeout with error pulse, and an idle gap between transactions.
module i2c_req_arbiter #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd500000,
    parameter logic [7:0]  GAP_CYC     = 8'd100
) (
    input  logic               CLK_50M,
    input  logic               RSTn,
    i2c_req_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] busy_cnt;
    logic [7:0]  gap_cnt;
    logic        last_grant;
    logic        owner;
    logic        req_any;
    logic        grant_sel;
    logic        timeout_hit;
    logic        gap_done;

    assign req_any     = bus.Req0 | bus.Req1;
    // On a tie the requester not served last wins; a lone request simply wins.
    assign grant_sel   = (bus.Req0 & bus.Req1) ? ~last_grant : bus.Req1;
    assign timeout_hit = (busy_cnt == TIMEOUT_CYC - 20'd1);
    assign gap_done    = (gap_cnt >= GAP_CYC - 8'd1) && !bus.Done_Sig;

    always_ff @(posedge CLK_50M) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = BUSY;
            BUSY:    if (bus.Done_Sig || timeout_hit) state_nxt = GAP;
            GAP:     if (gap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy = (state != IDLE);
    end

    always_ff @(posedge CLK_50M) begin
        if (!RSTn) begin
            busy_cnt      <= '0;
            gap_cnt       <= '0;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            bus.Start_Sig <= 2'b00;
            bus.Addr_Sig  <= 8'h00;
            bus.WrData    <= 8'h00;
            bus.RdData0   <= 8'h00;
            bus.RdData1   <= 8'h00;
            bus.Ack0      <= 1'b0;
            bus.Ack1      <= 1'b0;
            bus.Err0      <= 1'b0;
            bus.Err1      <= 1'b0;
        end else begin
            bus.Ack0 <= 1'b0;
            bus.Ack1 <= 1'b0;
            bus.Err0 <= 1'b0;
            bus.Err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        busy_cnt   <= '0;
                        if (grant_sel) begin
                            bus.Start_Sig <= {bus.Op1, ~bus.Op1};
                            bus.Addr_Sig  <= bus.Addr1;
                            bus.WrData    <= bus.Data1;
                        end else begin
                            bus.Start_Sig <= {bus.Op0, ~bus.Op0};
                            bus.Addr_Sig  <= bus.Addr0;
                            bus.WrData    <= bus.Data0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.Done_Sig || timeout_hit) begin
                        bus.Start_Sig <= 2'b00;
                        gap_cnt       <= '0;
                        // Done_Sig takes priority over a coincident timeout.
                        if (owner) begin
                            bus.Ack1 <= 1'b1;
                            bus.Err1 <= !bus.Done_Sig;
                            if (bus.Done_Sig && bus.Start_Sig[1]) bus.RdData1 <= bus.RdData;
                        end else begin
                            bus.Ack0 <= 1'b1;
                            bus.Err0 <= !bus.Done_Sig;
                            if (bus.Done_Sig && bus.Start_Sig[1]) bus.RdData0 <= bus.RdData;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + 20'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt < GAP_CYC - 8'd1) gap_cnt <= gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: write, read, reset, contention, timeout and boundary cases.
module tb_i2c_req_arbiter;

    localparam int GAP = 6;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    i2c_req_arbiter_if bus ();

    i2c_req_arbiter #(.TIMEOUT_CYC(20'd50), .GAP_CYC(8'd6)) dut (
        .CLK_50M (clk),
        .RSTn    (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait_idle: Busy=%b required 0", tag, bus.Busy);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Addr_Sig, bus.WrData} !== 18'h0) begin
            errors++;
            $display("FAIL reset_master: Start=%b Addr=%h WrData=%h required 0", bus.Start_Sig, bus.Addr_Sig, bus.WrData);
        end
        checks++;
        if ({bus.Ack0, bus.Ack1, bus.Err0, bus.Err1, bus.Busy, bus.RdData0, bus.RdData1} !== 21'h0) begin
            errors++;
            $display("FAIL reset_req: Ack=%b%b Err=%b%b Busy=%b Rd0=%h Rd1=%h required 0",
                     bus.Ack0, bus.Ack1, bus.Err0, bus.Err1, bus.Busy, bus.RdData0, bus.RdData1);
        end
        rstn = 1'b1;
    endtask

    task automatic test_write();
        int  busy_n = 0;
        bit  stable = 1'b1;
        bus.Req0 = 1'b1; bus.Op0 = 1'b0; bus.Addr0 = 8'h0e; bus.Data0 = 8'h40;
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Addr_Sig, bus.WrData} !== {2'b01, 8'h0e, 8'h40}) begin
            errors++;
            $display("FAIL write_issue: Start=%b Addr=%h WrData=%h required 01/0e/40", bus.Start_Sig, bus.Addr_Sig, bus.WrData);
        end
        if (bus.Busy) busy_n++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.Busy) busy_n++;
            if ({bus.Start_Sig, bus.Addr_Sig, bus.WrData, bus.Ack0} !== {2'b01, 8'h0e, 8'h40, 1'b0}) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL write_stable: Start/Addr/WrData moved or early Ack, got stable=%b required 1", stable);
        end
        bus.Done_Sig = 1'b1;
        tick();
        if (bus.Busy) busy_n++;
        checks++;
        if ({bus.Ack0, bus.Err0, bus.Ack1, bus.Start_Sig} !== {3'b100, 2'b00}) begin
            errors++;
            $display("FAIL write_ack: Ack0=%b Err0=%b Ack1=%b Start=%b required 1/0/0/00",
                     bus.Ack0, bus.Err0, bus.Ack1, bus.Start_Sig);
        end
        bus.Done_Sig = 1'b0;
        bus.Req0 = 1'b0;
        tick();
        if (bus.Busy) busy_n++;
        checks++;
        if (bus.Ack0 !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse: Ack0=%b required 0", bus.Ack0);
        end
        for (int i = 0; i < 300 && bus.Busy === 1'b1; i++) begin
            tick();
            if (bus.Busy) busy_n++;
        end
        checks++;
        if (busy_n != 21 + GAP) begin
            errors++;
            $display("FAIL write_busy_len: got %0d cycles required %0d", busy_n, 21 + GAP);
        end
    endtask

    task automatic test_read();
        bus.Req1 = 1'b1; bus.Op1 = 1'b1; bus.Addr1 = 8'h12; bus.Data1 = 8'h99;
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Addr_Sig} !== {2'b10, 8'h12}) begin
            errors++;
            $display("FAIL read_issue: Start=%b Addr=%h required 10/12", bus.Start_Sig, bus.Addr_Sig);
        end
        for (int i = 0; i < 5; i++) tick();
        bus.RdData = 8'hA5; bus.Done_Sig = 1'b1;
        tick();
        checks++;
        if ({bus.Ack1, bus.Err1, bus.Ack0, bus.RdData1} !== {3'b100, 8'hA5}) begin
            errors++;
            $display("FAIL read_ack: Ack1=%b Err1=%b Ack0=%b Rd1=%h required 1/0/0/a5", bus.Ack1, bus.Err1, bus.Ack0, bus.RdData1);
        end
        bus.Done_Sig = 1'b0; bus.RdData = 8'h00; bus.Req1 = 1'b0;
        wait_idle("read");
        checks++;
        if (bus.RdData1 !== 8'hA5) begin
            errors++;
            $display("FAIL read_hold: Rd1=%h required a5", bus.RdData1);
        end
    endtask

    task automatic test_reset_mid_busy();
        bus.Req0 = 1'b1; bus.Op0 = 1'b0; bus.Addr0 = 8'h55; bus.Data0 = 8'h66;
        tick();
        for (int i = 0; i < 10; i++) tick();
        rstn = 1'b0;
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Busy, bus.Ack0, bus.Addr_Sig, bus.RdData1} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid_busy: Start=%b Busy=%b Ack0=%b Addr=%h Rd1=%h required 0",
                     bus.Start_Sig, bus.Busy, bus.Ack0, bus.Addr_Sig, bus.RdData1);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Addr_Sig, bus.WrData} !== {2'b01, 8'h55, 8'h66}) begin
            errors++;
            $display("FAIL reset_regrant: Start=%b Addr=%h WrData=%h required 01/55/66", bus.Start_Sig, bus.Addr_Sig, bus.WrData);
        end
        bus.Done_Sig = 1'b1;
        tick();
        checks++;
        if ({bus.Ack0, bus.Err0} !== 2'b10) begin
            errors++;
            $display("FAIL reset_after_ack: Ack0=%b Err0=%b required 1/0", bus.Ack0, bus.Err0);
        end
        bus.Done_Sig = 1'b0; bus.Req0 = 1'b0;
        wait_idle("reset_mid_busy");
    endtask

    task automatic test_contention();
        logic [7:0] exp_addr;
        logic [1:0] exp_ack;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        bus.Req0 = 1'b1; bus.Op0 = 1'b0; bus.Addr0 = 8'h01; bus.Data0 = 8'h11;
        bus.Req1 = 1'b1; bus.Op1 = 1'b0; bus.Addr1 = 8'h02; bus.Data1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 1) ? 8'h02 : 8'h01;
            exp_ack  = (k % 2 == 1) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (bus.Addr_Sig !== exp_addr) begin
                errors++;
                $display("FAIL contention_grant%0d: Addr=%h required %h", k, bus.Addr_Sig, exp_addr);
            end
            bus.Done_Sig = 1'b1;
            tick();
            checks++;
            if ({bus.Ack0, bus.Ack1} !== exp_ack) begin
                errors++;
                $display("FAIL contention_ack%0d: Ack0/1=%b%b required %b", k, bus.Ack0, bus.Ack1, exp_ack);
            end
            bus.Done_Sig = 1'b0;
            wait_idle("contention");
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        bus.Req0 = 1'b1; bus.Op0 = 1'b1; bus.Addr0 = 8'h20;
        tick();
        bus.RdData = 8'h3C; bus.Done_Sig = 1'b1;
        tick();
        checks++;
        if (bus.RdData0 !== 8'h3C) begin
            errors++;
            $display("FAIL timeout_preload: Rd0=%h required 3c", bus.RdData0);
        end
        bus.Done_Sig = 1'b0; bus.Req0 = 1'b0; bus.RdData = 8'hFF;
        wait_idle("timeout_pre");
        bus.Req0 = 1'b1;
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (bus.Ack0 !== 1'b0 || bus.Start_Sig !== 2'b10) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL timeout_early: early Ack0 or Start change, got flag=%b required 0", early);
        end
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Ack0, bus.Err0, bus.RdData0} !== {2'b00, 2'b11, 8'h3C}) begin
            errors++;
            $display("FAIL timeout_fire: Start=%b Ack0=%b Err0=%b Rd0=%h required 00/1/1/3c",
                     bus.Start_Sig, bus.Ack0, bus.Err0, bus.RdData0);
        end
        bus.Req0 = 1'b0; bus.RdData = 8'h00;
        tick();
        checks++;
        if ({bus.Ack0, bus.Err0} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: Ack0=%b Err0=%b required 0/0", bus.Ack0, bus.Err0);
        end
        wait_idle("timeout");
    endtask

    task automatic test_timeout_tie();
        bus.Req1 = 1'b1; bus.Op1 = 1'b1; bus.Addr1 = 8'h33;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        bus.Done_Sig = 1'b1; bus.RdData = 8'h77;
        tick();
        checks++;
        if ({bus.Start_Sig, bus.Ack1, bus.Err1, bus.RdData1} !== {2'b00, 2'b10, 8'h77}) begin
            errors++;
            $display("FAIL tie_done_wins: Start=%b Ack1=%b Err1=%b Rd1=%h required 00/1/0/77",
                     bus.Start_Sig, bus.Ack1, bus.Err1, bus.RdData1);
        end
        bus.Done_Sig = 1'b0; bus.RdData = 8'h00; bus.Req1 = 1'b0;
        wait_idle("tie");
    endtask

    task automatic test_gap_extend();
        int gap_n = 0;
        bus.Req0 = 1'b1; bus.Op0 = 1'b0; bus.Addr0 = 8'h44;
        tick();
        bus.Req0 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.Done_Sig = 1'b1;
        tick();
        checks++;
        if (bus.Ack0 !== 1'b1) begin
            errors++;
            $display("FAIL gap_ack: Ack0=%b required 1", bus.Ack0);
        end
        if (bus.Busy) gap_n++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.Busy) gap_n++;
        end
        bus.Done_Sig = 1'b0;
        for (int i = 0; i < 100 && bus.Busy === 1'b1; i++) begin
            tick();
            if (bus.Busy) gap_n++;
        end
        checks++;
        if (gap_n != 11) begin
            errors++;
            $display("FAIL gap_extend: GAP lasted %0d cycles required 11", gap_n);
        end
    endtask

    task automatic test_req_drop();
        bus.Req0 = 1'b1; bus.Op0 = 1'b0; bus.Addr0 = 8'h5A;
        tick();
        checks++;
        if (bus.Start_Sig !== 2'b01) begin
            errors++;
            $display("FAIL drop_issue: Start=%b required 01", bus.Start_Sig);
        end
        for (int i = 0; i < 3; i++) tick();
        bus.Req0 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.Done_Sig = 1'b1;
        tick();
        checks++;
        if ({bus.Ack0, bus.Err0} !== 2'b10) begin
            errors++;
            $display("FAIL drop_ack: Ack0=%b Err0=%b required 1/0", bus.Ack0, bus.Err0);
        end
        bus.Done_Sig = 1'b0;
        wait_idle("drop");
        tick();
        tick();
        checks++;
        if ({bus.Busy, bus.Start_Sig} !== 3'b000) begin
            errors++;
            $display("FAIL drop_no_regrant: Busy=%b Start=%b required 0/00", bus.Busy, bus.Start_Sig);
        end
    endtask

    task automatic test_done_idle();
        bus.Done_Sig = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({bus.Busy, bus.Ack0, bus.Ack1, bus.Start_Sig} !== 5'b0) begin
            errors++;
            $display("FAIL done_idle: Busy=%b Ack=%b%b Start=%b required 0",
                     bus.Busy, bus.Ack0, bus.Ack1, bus.Start_Sig);
        end
        bus.Done_Sig = 1'b0;
    endtask

    initial begin
        bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.Op0 = 1'b0; bus.Op1 = 1'b0;
        bus.Addr0 = 8'h00; bus.Addr1 = 8'h00; bus.Data0 = 8'h00; bus.Data1 = 8'h00;
        bus.RdData = 8'h00; bus.Done_Sig = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_reset_mid_busy();
        test_contention();
        test_timeout();
        test_timeout_tie();
        test_gap_extend();
        test_req_drop();
        test_done_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
